// File: rtl/mult_pkg.sv
// Shared types for the sequential Booth multiplier: FSM states, Booth digit, step count.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic neg;
        logic one;
        logic two;
    } booth_digit_t;

    // Radix-4 digits needed to cover b plus its extension bit.
    function automatic int nstep(input int width_b);
        return (width_b + 2) / 2;
    endfunction

endpackage

// File: rtl/booth_r4_encoder.sv
// Radix-4 Booth recoder: triple {b[2i+1], b[2i], b[2i-1]} -> digit in {0, +-1, +-2}.
// Purely combinational, no handshake.
module booth_r4_encoder
    import mult_pkg::*;
(
    input  logic [2:0]   triple_i,
    output booth_digit_t digit_o
);

    always_comb begin
        digit_o.neg = triple_i[2] & ~(triple_i[1] & triple_i[0]);
        digit_o.one = triple_i[1] ^ triple_i[0];
        digit_o.two = (triple_i == 3'b011) | (triple_i == 3'b100);
    end

endmodule

// File: rtl/booth_seq_multiplier.sv
// Iterative radix-4 Booth multiplier with optional accumulator, one digit per clock.
// out_valid rises NSTEP edges after accept; result and acc hold until out_ready retires them.
module booth_seq_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH_A   = 9,
    parameter int WIDTH_B   = 5,
    parameter int ACC_WIDTH = 24
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH_A-1:0]         a,
    input  logic [WIDTH_B-1:0]         b,
    input  logic                       is_signed,
    input  logic                       acc_en,
    input  logic                       acc_clr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH_A+WIDTH_B-1:0] product,
    output logic [ACC_WIDTH-1:0]       acc,
    output logic                       busy
);

    localparam int NSTEP = nstep(WIDTH_B);
    localparam int AW    = WIDTH_A + 2;
    localparam int BW    = 2 * NSTEP + 1;
    localparam int PW    = AW + 2 * NSTEP;
    localparam int RW    = WIDTH_A + WIDTH_B;
    localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;

    if (WIDTH_A < 2) begin : g_bad_width_a
        $error("booth_seq_multiplier: WIDTH_A must be >= 2");
    end
    if (WIDTH_B < 2) begin : g_bad_width_b
        $error("booth_seq_multiplier: WIDTH_B must be >= 2");
    end
    if (ACC_WIDTH < WIDTH_A + WIDTH_B) begin : g_bad_acc_width
        $error("booth_seq_multiplier: ACC_WIDTH must be >= WIDTH_A+WIDTH_B");
    end

    state_t                 state_q;
    logic [CW-1:0]          cnt_q;
    logic signed [AW-1:0]   a_ext_q;
    logic [BW-1:0]          b_q;
    logic [PW-1:0]          psum_q;
    logic [RW-1:0]          product_q;
    logic [ACC_WIDTH-1:0]   acc_q;
    logic                   is_signed_q;
    logic                   acc_en_q;
    logic                   acc_clr_q;

    logic                   a_top;
    logic                   b_top;
    logic signed [AW-1:0]   a_ext_d;
    logic [BW-1:0]          b_ext_d;
    booth_digit_t           digit;
    logic signed [AW-1:0]   mag;
    logic signed [AW-1:0]   pp;
    logic [PW-1:0]          pp_sh;
    logic [PW-1:0]          psum_d;
    logic [ACC_WIDTH-1:0]   prod_ext;

    booth_r4_encoder u_enc (
        .triple_i (b_q[2:0]),
        .digit_o  (digit)
    );

    always_comb begin
        a_top   = is_signed & a[WIDTH_A-1];
        b_top   = is_signed & b[WIDTH_B-1];
        a_ext_d = {{2{a_top}}, a};
        // LSB is the implicit b[-1] = 0 of the first Booth triple.
        b_ext_d = {{(2*NSTEP-WIDTH_B){b_top}}, b, 1'b0};

        mag = '0;
        if (digit.one) begin
            mag = a_ext_q;
        end else if (digit.two) begin
            mag = a_ext_q <<< 1;
        end
        pp     = digit.neg ? -mag : mag;
        pp_sh  = PW'(pp) << {cnt_q, 1'b0};
        psum_d = psum_q + pp_sh;

        if (is_signed_q) begin
            prod_ext = ACC_WIDTH'($signed(product_q));
        end else begin
            prod_ext = ACC_WIDTH'(product_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_ext_q     <= '0;
            b_q         <= '0;
            psum_q      <= '0;
            product_q   <= '0;
            acc_q       <= '0;
            is_signed_q <= 1'b0;
            acc_en_q    <= 1'b0;
            acc_clr_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_ext_q     <= a_ext_d;
                        b_q         <= b_ext_d;
                        is_signed_q <= is_signed;
                        acc_en_q    <= acc_en;
                        acc_clr_q   <= acc_clr;
                        psum_q      <= '0;
                        cnt_q       <= '0;
                        state_q     <= CALC;
                    end
                end
                CALC: begin
                    psum_q <= psum_d;
                    b_q    <= {2'b00, b_q[BW-1:2]};
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == CW'(NSTEP - 1)) begin
                        product_q <= psum_d[RW-1:0];
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        if (acc_clr_q) begin
                            acc_q <= prod_ext;
                        end else if (acc_en_q) begin
                            acc_q <= acc_q + prod_ext;
                        end
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == CALC) || (state_q == DONE);
    assign product   = product_q;
    assign acc       = acc_q;

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Directed and random checks of booth_seq_multiplier at default widths (9x5, 24-bit acc).
module tb_booth_seq_multiplier;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [8:0]  a;
    logic [4:0]  b;
    logic        is_signed;
    logic        acc_en;
    logic        acc_clr;
    logic        out_valid;
    logic        out_ready;
    logic [13:0] product;
    logic [23:0] acc;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    booth_seq_multiplier #(
        .WIDTH_A   (9),
        .WIDTH_B   (5),
        .ACC_WIDTH (24)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .is_signed (is_signed),
        .acc_en    (acc_en),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .acc       (acc),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // One full operation: accept, wait for out_valid, retire. Returns product, latency, busy history.
    task automatic run_op(input logic [8:0] ta, input logic [4:0] tb_v, input logic s,
                          input logic en, input logic clr,
                          output logic [13:0] p, output int lat, output logic bz);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) check_val("ready_timeout", {31'd0, in_ready}, 32'd1);
        a = ta; b = tb_v; is_signed = s; acc_en = en; acc_clr = clr;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 9'h0AA; b = 5'h15; is_signed = ~s; acc_en = ~en; acc_clr = ~clr;
        bz  = busy;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            bz &= busy;
        end
        check_val("latency", lat, 32'd3);
        p = product;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    logic [13:0] p;
    int          lat;
    logic        bz;
    logic [23:0] acc_m;
    logic [8:0]  ra;
    logic [4:0]  rb;
    logic        rs, ren, rclr;
    int          ia, ib, ep;
    logic [13:0] ep14;
    int          n;

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; is_signed = 1'b0;
        acc_en = 1'b0; acc_clr = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_product", {18'd0, product}, 32'd0);
        check_val("rst_acc", {8'd0, acc}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Signed extremes: -256 * -16 = 4096
        run_op(9'h100, 5'h10, 1'b1, 1'b0, 1'b0, p, lat, bz);
        check_val("sgn_ext_prod", {18'd0, p}, 32'h1000);
        check_val("sgn_ext_busy", {31'd0, bz}, 32'd1);
        check_val("sgn_ext_busy_after", {31'd0, busy}, 32'd0);

        // Unsigned extremes: 511 * 31 = 15841
        run_op(9'd511, 5'd31, 1'b0, 1'b0, 1'b0, p, lat, bz);
        check_val("uns_ext_prod", {18'd0, p}, 32'h3DE1);
        check_val("uns_acc_untouched", {8'd0, acc}, 32'd0);

        // Backpressure: second operand presented throughout, must wait for retirement.
        a = 9'd3; b = 5'd5; is_signed = 1'b0; acc_en = 1'b0; acc_clr = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        a = 9'd7; b = 5'd7;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check_val("bp_valid", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check_val("bp_prod_stable", {18'd0, product}, 32'd15);
            check_val("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        check_val("bp_still_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_val("bp_idle_after_retire", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_val("bp_second_accepted", {31'd0, busy}, 32'd1);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check_val("bp_second_prod", {18'd0, product}, 32'd49);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Accumulate: 3*4 with clear, then -5*7 added (signed).
        run_op(9'd3, 5'd4, 1'b1, 1'b0, 1'b1, p, lat, bz);
        check_val("accum_clr", {8'd0, acc}, 32'd12);
        run_op(9'h1FB, 5'd7, 1'b1, 1'b1, 1'b0, p, lat, bz);
        check_val("accum_neg_prod", {18'd0, p}, 32'h3FDD);
        check_val("accum_en", {8'd0, acc}, 32'hFFFFE9);

        // Build acc = 0x7FFFFF from unsigned products: 529*15841 + 511*17 + 31*1.
        run_op(9'd511, 5'd31, 1'b0, 1'b0, 1'b1, p, lat, bz);
        for (int i = 0; i < 528; i++) run_op(9'd511, 5'd31, 1'b0, 1'b1, 1'b0, p, lat, bz);
        run_op(9'd511, 5'd17, 1'b0, 1'b1, 1'b0, p, lat, bz);
        run_op(9'd31, 5'd1, 1'b0, 1'b1, 1'b0, p, lat, bz);
        check_val("wrap_pre", {8'd0, acc}, 32'h7FFFFF);
        run_op(9'd1, 5'd1, 1'b1, 1'b1, 1'b0, p, lat, bz);
        check_val("wrap_post", {8'd0, acc}, 32'h800000);
        run_op(9'd2, 5'd3, 1'b0, 1'b0, 1'b0, p, lat, bz);
        check_val("hold_prod", {18'd0, p}, 32'd6);
        check_val("hold_acc", {8'd0, acc}, 32'h800000);

        // Reset during the last CALC step discards the operation.
        a = 9'd5; b = 5'd3; is_signed = 1'b0; acc_en = 1'b1; acc_clr = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_val("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("midrst_acc", {8'd0, acc}, 32'd0);
        check_val("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check_val("midrst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_val("midrst_no_output", {31'd0, out_valid}, 32'd0);

        // Random operations against a golden product and accumulator model.
        acc_m = '0;
        for (int i = 0; i < 2000; i++) begin
            ra   = 9'($urandom);
            rb   = 5'($urandom);
            rs   = 1'($urandom_range(0, 1));
            ren  = 1'($urandom_range(0, 1));
            rclr = ($urandom_range(0, 7) == 0);
            ia   = rs ? int'($signed(ra)) : int'(ra);
            ib   = rs ? int'($signed(rb)) : int'(rb);
            ep   = ia * ib;
            ep14 = 14'(ep);
            run_op(ra, rb, rs, ren, rclr, p, lat, bz);
            check_val("rand_prod", {18'd0, p}, {18'd0, ep14});
            if (rclr) acc_m = 24'(ep);
            else if (ren) acc_m = acc_m + 24'(ep);
            check_val("rand_acc", {8'd0, acc}, {8'd0, acc_m});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/booth_seq_multiplier.md
# booth_seq_multiplier

Iterative radix-4 Booth multiplier with a valid/ready handshake, a per-operation signed/unsigned mode and an optional running accumulator. It retires one Booth digit per clock. It is the area-lean successor to the combinational multiplier in the CNN datapath, used where one multiplier is time-shared across kernel taps and the MAC sum is built inside the block.

## Interface
- WIDTH_A, 9, width of operand a (>= 2)
- WIDTH_B, 5, width of operand b (>= 2); sets the digit count
- ACC_WIDTH, 24, accumulator width (>= WIDTH_A+WIDTH_B)
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept operands
- a  in  WIDTH_A  multiplicand
- b  in  WIDTH_B  multiplier; Booth-recoded
- is_signed  in  1  1 = both operands two's complement; 0 = both unsigned
- acc_en  in  1  add this product to the accumulator at retirement
- acc_clr  in  1  load the accumulator with this product at retirement; has priority over acc_en
- out_valid  out  1  product valid
- out_ready  in  1  consumer takes the product
- product  out  WIDTH_A+WIDTH_B  result; signed or unsigned per the captured is_signed
- acc  out  ACC_WIDTH  accumulator register, two's complement
- busy  out  1  high in CALC or DONE

## Operation
- NSTEP = (WIDTH_B+2)/2, using integer division. The default gives 3.
- On the accept edge, a, b, is_signed, acc_en and acc_clr are captured.
- b is extended by one bit (sign or zero per mode), then padded to 2·NSTEP bits, with an implicit b[-1] = 0.
- a is extended the same way into a WIDTH_A+2 partial-sum domain, so that ±2a cannot overflow.
- FSM states and transitions:
  - IDLE: in_ready = 1. An edge with in_valid = 1 captures the operands, clears the partial sum and step counter, and moves to CALC.
  - CALC: each edge encodes digit triple {b[2i+1], b[2i], b[2i-1]} into {0, ±a, ±2a} and adds it at weight 4^i. The counter increments. After step NSTEP-1 the state moves to DONE.
  - DONE: out_valid = 1. product holds the low WIDTH_A+WIDTH_B bits of the partial sum.
  - DONE, on an edge with out_ready = 1: the state returns to IDLE and the accumulator is updated.
- Accumulator update at retirement:
  - acc_clr: acc ← ext(product).
  - acc_en and not acc_clr: acc ← acc + ext(product).
  - Neither: acc unchanged.
  - ext() sign-extends in signed mode and zero-extends in unsigned mode. The sum wraps modulo 2^ACC_WIDTH with no saturation.
- in_ready is low in CALC and DONE. in_valid in those states is ignored and nothing is captured.
- Inputs other than out_ready are don't-care outside the accept edge.
- product and acc are stable while out_valid = 1 and out_ready = 0.

## Timing
- Reset values: state IDLE, in_ready 1, out_valid 0, busy 0, product 0, acc 0, step counter 0.
- Reset in the middle of an operation discards it completely, with no partial output and no accumulator update.
- Latency: out_valid rises NSTEP edges after the accept edge (3 for the defaults).
- Retirement consumes one more edge; the next accept is possible on the edge after that.
- Back-to-back throughput is one result per NSTEP+2 cycles.
- in_ready, out_valid and busy decode directly from state registers, with no combinational path from in_valid or out_ready.
- product is registered and changes only on the edge that enters DONE.
- acc changes only on a retirement edge.

## Structure
- Shared package mult_pkg:
  - state enum {IDLE, CALC, DONE}
  - constant function nstep(width_b)
  - Booth digit type {neg, one, two}
- One sub-module: booth_r4_encoder, a combinational block mapping 3 bits to {neg, one, two}.
- Elaboration-time checks enforce WIDTH_A >= 2, WIDTH_B >= 2 and ACC_WIDTH >= WIDTH_A+WIDTH_B.

## Test plan
- Signed extremes: is_signed=1, a=-256, b=-16 → product=4096 (0x1000), out_valid exactly 3 cycles after accept, busy high from accept through retirement.
- Unsigned extremes: is_signed=0, a=511, b=31 → product=15841 (0x3DE1).
- Backpressure: out_ready held low 5 cycles with in_valid=1 throughout → product stable, in_ready=0, second operand not captured; accepted only after retirement.
- Accumulate: 3×4 with acc_clr, then -5×7 with acc_en (signed) → acc=12, then acc=-23 (0xFFFFE9).
- Wrap and hold: acc=0x7FFFFF, then 1×1 with acc_en → acc=0x800000; a following op with acc_en=acc_clr=0 leaves acc unchanged.
- Reset mid-CALC: rst_n low on step 2 → out_valid=0, acc=0, in_ready=1 immediately; after release, 2000 random ops in both modes match a golden a×b model.
